// File: rtl/lsu_mem_ctrl_pkg.sv
// lsu_mem_ctrl_pkg: funct3 encodings and LSU state type, shared with the control unit.
package lsu_mem_ctrl_pkg;
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_e;

   function automatic logic f3_legal(input logic we, input logic [2:0] f3);
      return we ? (f3 < 3'b011) : (f3 != 3'b011 && f3 < 3'b110);
   endfunction
endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// lsu_mem_ctrl_if: req/gnt/rvalid data-memory bus between the LSU and memory.
interface lsu_mem_ctrl_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;

   modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
   modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/lsu_mem_ctrl_lane_align.sv
// lsu_mem_ctrl_lane_align: byte-lane steering for stores, extraction/extension for loads, alignment check.
module lsu_mem_ctrl_lane_align
   import lsu_mem_ctrl_pkg::*;
(
   input  logic        wren,
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] st_data,
   input  logic [2:0]  ld_funct3,
   input  logic [1:0]  ld_addr_lo,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] ld_data,
   output logic        bad
);
   logic [7:0]  b;
   logic [15:0] h;
   logic        sx;

   always_comb begin
      bad     = !f3_legal(wren, funct3) || (funct3[1:0] == 2'b01 && addr_lo[0]) ||
                (funct3[1:0] == 2'b10 && addr_lo != 2'b00);
      be      = funct3[1:0] == 2'b00 ? 4'b0001 << addr_lo :
                funct3[1:0] == 2'b01 ? (addr_lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      wdata   = funct3[1:0] == 2'b00 ? {4{st_data[7:0]}} :
                funct3[1:0] == 2'b01 ? {2{st_data[15:0]}} : st_data;
      b       = rdata[{ld_addr_lo, 3'b000} +: 8];
      h       = ld_addr_lo[1] ? rdata[31:16] : rdata[15:0];
      sx      = !ld_funct3[2];
      ld_data = ld_funct3[1:0] == 2'b00 ? {{24{sx & b[7]}}, b} :
                ld_funct3[1:0] == 2'b01 ? {{16{sx & h[15]}}, h} : rdata;
   end
endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store unit FSM driving a req/gnt/rvalid data bus, stalling the core per access.
module lsu_mem_ctrl
   import lsu_mem_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 64
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req,
   input  logic                  wren,
   input  logic [2:0]            funct3,
   input  logic [31:0]           addr,
   input  logic [31:0]           st_data,
   output logic                  stall,
   output logic                  ld_vld,
   output logic [31:0]           ld_data,
   output logic                  misalign,
   output logic                  busfault,
   lsu_mem_ctrl_if.master        mem
);
   lsu_state_e  st, nxt;
   logic [7:0]  timer;
   logic        we_q;
   logic [2:0]  f3_q;
   logic [1:0]  lo_q;
   logic [29:0] word_q;
   logic [3:0]  be_q, be;
   logic [31:0] wd_q, wdata, ext;
   logic        bad, cap, tmo, timeout, accept;

   lsu_mem_ctrl_lane_align u_align (
      .wren       (wren),
      .funct3     (funct3),
      .addr_lo    (addr[1:0]),
      .st_data    (st_data),
      .ld_funct3  (f3_q),
      .ld_addr_lo (lo_q),
      .rdata      (mem.rdata),
      .be         (be),
      .wdata      (wdata),
      .ld_data    (ext),
      .bad        (bad)
   );

   assign timeout   = timer == 8'(TIMEOUT_CYC - 1);
   assign accept    = st == IDLE && req && !bad;
   // Reset also clears the combinational handshake outputs so the core is released at once.
   assign stall     = !rst && (st == IDLE ? req && !bad : st != DONE);
   assign misalign  = !rst && st == IDLE && req && bad;
   assign mem.req   = st == REQ;
   assign mem.we    = we_q;
   assign mem.addr  = {word_q, 2'b00};
   assign mem.be    = be_q;
   assign mem.wdata = wd_q;

   always_comb begin
      cap = !we_q && mem.rvalid && (st == WAIT || (st == REQ && mem.gnt));
      tmo = timeout && (st == WAIT ? !mem.rvalid : st == REQ && !mem.gnt);
      nxt = st == IDLE ? (accept ? REQ : IDLE) :
            st == DONE ? IDLE :
            cap || tmo || (st == REQ && mem.gnt && we_q) ? DONE :
            st == REQ && mem.gnt ? WAIT : st;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st       <= IDLE;
         timer    <= '0;
         we_q     <= 1'b0;
         f3_q     <= '0;
         lo_q     <= '0;
         word_q   <= '0;
         be_q     <= '0;
         wd_q     <= '0;
         ld_vld   <= 1'b0;
         busfault <= 1'b0;
         ld_data  <= '0;
      end else begin
         st       <= nxt;
         timer    <= (st == REQ || st == WAIT) ? timer + 8'd1 : 8'd0;
         ld_vld   <= nxt == DONE && !we_q && !tmo;
         busfault <= tmo;
         if (cap)
            ld_data <= ext;
         else if (tmo)
            ld_data <= '0;
         if (accept) begin
            we_q   <= wren;
            f3_q   <= funct3;
            lo_q   <= addr[1:0];
            word_q <= addr[31:2];
            be_q   <= be;
            wd_q   <= wdata;
         end
      end
   end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: directed accesses; expected core events and bus beats are queued and checked by a monitor.
module tb_lsu_mem_ctrl;
   import lsu_mem_ctrl_pkg::*;

   localparam logic [2:0] K_ST  = 3'b000;
   localparam logic [2:0] K_LD  = 3'b100;
   localparam logic [2:0] K_MIS = 3'b010;
   localparam logic [2:0] K_BF  = 3'b001;

   typedef struct {logic [2:0] kind; logic [31:0] data;} ev_t;
   typedef struct {logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata;} bus_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req, wren;
   logic [2:0]  funct3;
   logic [31:0] addr, st_data;
   logic        stall, ld_vld, misalign, busfault;
   logic [31:0] ld_data;

   ev_t  evq[$];
   bus_t busq[$];
   ev_t  ev;
   bus_t bx;
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   lsu_mem_ctrl_if mem();

   lsu_mem_ctrl dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .wren     (wren),
      .funct3   (funct3),
      .addr     (addr),
      .st_data  (st_data),
      .stall    (stall),
      .ld_vld   (ld_vld),
      .ld_data  (ld_data),
      .misalign (misalign),
      .busfault (busfault),
      .mem      (mem)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && (ld_vld || misalign || busfault)) begin
         if (evq.size() == 0)
            chk("unexpected_event", {29'd0, ld_vld, misalign, busfault}, 32'd0);
         else begin
            ev = evq.pop_front();
            chk("event_kind", {29'd0, ld_vld, misalign, busfault}, {29'd0, ev.kind});
            if (ev.kind != K_MIS)
               chk("event_ld_data", ld_data, ev.data);
         end
      end
      if (!rst && mem.req && mem.gnt) begin
         if (busq.size() == 0)
            chk("unexpected_bus", {31'd0, mem.gnt}, 32'd0);
         else begin
            bx = busq.pop_front();
            chk("bus_we", {31'd0, mem.we}, {31'd0, bx.we});
            chk("bus_addr", mem.addr, bx.addr);
            chk("bus_be", {28'd0, mem.be}, {28'd0, bx.be});
            chk("bus_wdata", mem.wdata, bx.wdata);
         end
      end
   end

   // gw: request cycles before gnt (-1 = never); rw: cycles from gnt to rvalid.
   task automatic access(input string nm, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d, input int gw, input int rw,
                         input logic [31:0] rd, input int exp_stall, input logic [2:0] kind,
                         input logic [31:0] exp_ld, input logic [3:0] exp_be, input logic [31:0] exp_wd);
      int rq = 0;
      int since = -1;
      int st = 0;
      bit done = 1'b0;
      if (kind != K_MIS && gw >= 0)
         busq.push_back(bus_t'{we, {a[31:2], 2'b00}, exp_be, exp_wd});
      if (kind != K_ST)
         evq.push_back(ev_t'{kind, exp_ld});
      req = 1'b1; wren = we; funct3 = f3; addr = a; st_data = d;
      while (!done && st < 300) begin
         mem.gnt = mem.req && gw >= 0 && rq >= gw;
         if (mem.req) rq++;
         if (mem.gnt) since = 0;
         else if (since >= 0) since++;
         mem.rvalid = !we && since == rw;
         mem.rdata  = mem.rvalid ? rd : 32'h5A5A_5A5A;
         #1;
         if (!stall) done = 1'b1;
         else begin
            st++;
            @(posedge clk); #1;
         end
      end
      chk({nm, "_released"}, {31'd0, done}, 32'd1);
      chk({nm, "_stall_cycles"}, 32'(st), 32'(exp_stall));
      chk({nm, "_mem_req_low"}, {31'd0, mem.req}, 32'd0);
      @(posedge clk); #1;
      req = 1'b0; mem.gnt = 1'b0; mem.rvalid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      req = 1'b0; wren = 1'b0; funct3 = '0; addr = '0; st_data = '0;
      mem.gnt = 1'b0; mem.rvalid = 1'b0; mem.rdata = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_stall", {31'd0, stall}, 32'd0);
      chk("rst_mem_req", {31'd0, mem.req}, 32'd0);
      chk("rst_ld_vld", {31'd0, ld_vld}, 32'd0);
      chk("rst_busfault", {31'd0, busfault}, 32'd0);
      chk("rst_ld_data", ld_data, 32'd0);
      chk("rst_mem_be", {28'd0, mem.be}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      access("lw_104", 1'b0, F3_LW, 32'h104, 32'h0, 0, 1, 32'hDEADBEEF, 3, K_LD, 32'hDEADBEEF, 4'b1111, 32'h0);
      access("lb_103", 1'b0, F3_LB, 32'h103, 32'h0, 2, 1, 32'h80FF0000, 5, K_LD, 32'hFFFFFF80, 4'b1000, 32'h0);
      access("lbu_103", 1'b0, F3_LBU, 32'h103, 32'h0, 0, 0, 32'h80FF0000, 2, K_LD, 32'h00000080, 4'b1000, 32'h0);
      access("sh_102", 1'b1, F3_SH, 32'h102, 32'h0000ABCD, 1, 0, 32'h0, 3, K_ST, 32'h0, 4'b1100, 32'hABCDABCD);
      access("lw_102_mis", 1'b0, F3_LW, 32'h102, 32'h0, 0, 0, 32'h0, 0, K_MIS, 32'h0, 4'b0000, 32'h0);
      access("lh_102", 1'b0, F3_LH, 32'h102, 32'h0, 0, 1, 32'h80011234, 3, K_LD, 32'hFFFF8001, 4'b1100, 32'h0);
      access("lhu_100", 1'b0, F3_LHU, 32'h100, 32'h0, 1, 2, 32'h8001F234, 5, K_LD, 32'h0000F234, 4'b0011, 32'h0);
      access("sb_105", 1'b1, F3_SB, 32'h105, 32'h12345678, 0, 0, 32'h0, 2, K_ST, 32'h0, 4'b0010, 32'h78787878);
      access("sw_108", 1'b1, F3_SW, 32'h108, 32'hCAFEF00D, 0, 0, 32'h0, 2, K_ST, 32'h0, 4'b1111, 32'hCAFEF00D);
      access("ld_f3_011", 1'b0, 3'b011, 32'h0, 32'h0, 0, 0, 32'h0, 0, K_MIS, 32'h0, 4'b0000, 32'h0);
      access("ld_f3_110", 1'b0, 3'b110, 32'h0, 32'h0, 0, 0, 32'h0, 0, K_MIS, 32'h0, 4'b0000, 32'h0);
      access("st_f3_011", 1'b1, 3'b011, 32'h0, 32'h0, 0, 0, 32'h0, 0, K_MIS, 32'h0, 4'b0000, 32'h0);
      access("sh_101_mis", 1'b1, F3_SH, 32'h101, 32'h0, 0, 0, 32'h0, 0, K_MIS, 32'h0, 4'b0000, 32'h0);
      access("lw_timeout", 1'b0, F3_LW, 32'h200, 32'h0, -1, 0, 32'h0, 65, K_BF, 32'h0, 4'b1111, 32'h0);
      mem.rvalid = 1'b1; mem.rdata = 32'h11111111;
      repeat (3) begin
         @(posedge clk); #1;
         chk("stale_rvalid_ld_vld", {31'd0, ld_vld}, 32'd0);
      end
      mem.rvalid = 1'b0;
      chk("stale_rvalid_ld_data", ld_data, 32'd0);
      busq.push_back(bus_t'{1'b0, 32'h300, 4'b1111, 32'h0});
      req = 1'b1; wren = 1'b0; funct3 = F3_LW; addr = 32'h300; st_data = '0;
      @(posedge clk); #1;
      chk("rst_wait_req_high", {31'd0, mem.req}, 32'd1);
      mem.gnt = 1'b1;
      @(posedge clk); #1;
      mem.gnt = 1'b0;
      chk("rst_wait_stall_high", {31'd0, stall}, 32'd1);
      rst = 1'b1;
      #1;
      chk("rst_wait_stall_low", {31'd0, stall}, 32'd0);
      chk("rst_wait_req_low", {31'd0, mem.req}, 32'd0);
      req = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      mem.rvalid = 1'b1; mem.rdata = 32'hBAD0BAD0;
      @(posedge clk); #1;
      mem.rvalid = 1'b0;
      chk("rst_wait_no_ld_vld", {31'd0, ld_vld}, 32'd0);
      chk("rst_wait_ld_data", ld_data, 32'd0);
      access("lw_10c_fresh", 1'b0, F3_LW, 32'h10C, 32'h0, 0, 1, 32'h0BADC0DE, 3, K_LD, 32'h0BADC0DE, 4'b1111, 32'h0);
      repeat (3) @(posedge clk);
      #1;
      chk("event_queue_drained", 32'(evq.size()), 32'd0);
      chk("bus_queue_drained", 32'(busq.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
